// File: rtl/serial_mod_detector_if.sv
// Purpose : bundles the serial-bit stream controls and the detector's registered status.
// Ports   : start/din_valid/din (stream in), rem/divisible/nonzero/bit_count (status out).
// Latency : status reflects the bit sampled on the previous rising edge; no backpressure, every valid bit is consumed.
interface serial_mod_detector_if #(
   parameter int RW      = 3,
   parameter int COUNT_W = 8
);
   logic               start;
   logic               din_valid;
   logic               din;
   logic [RW-1:0]      rem;
   logic               divisible;
   logic               nonzero;
   logic [COUNT_W-1:0] bit_count;

   modport master (
      output start, din_valid, din,
      input  rem, divisible, nonzero, bit_count
   );

   modport slave (
      input  start, din_valid, din,
      output rem, divisible, nonzero, bit_count
   );
endinterface

// File: rtl/serial_mod_detector.sv
// Purpose : running remainder of a serial bit stream modulo DIVISOR (MSB- or LSB-first), with divisibility flag.
// Ports   : clk, reset (async, active-high), bus (slave: start/din_valid/din in; rem/divisible/nonzero/bit_count out).
// Latency : one cycle, a bit sampled on edge N shows after edge N; no backpressure, din is taken whenever din_valid is high.
module serial_mod_detector #(
   parameter int DIVISOR   = 5,
   parameter int LSB_FIRST = 0,
   parameter int COUNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   serial_mod_detector_if.slave bus
);
   localparam int RW = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1;

   localparam logic [RW:0]   DIV_C = (RW+1)'(DIVISOR);
   localparam logic [RW-1:0] W_ONE = RW'(1);

   logic [RW-1:0]      rem_q, rem_b, rem_n;
   logic [RW-1:0]      w_q, w_b, w_n;
   logic               nz_q, nz_b, nz_n;
   logic [COUNT_W-1:0] cnt_q, cnt_b, cnt_n;
   logic [RW:0]        t;
   logic [RW:0]        tw;

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         w_q   <= W_ONE;
         nz_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_n;
         w_q   <= w_n;
         nz_q  <= nz_n;
         cnt_q <= cnt_n;
      end
   end

   always_comb begin
      // start wipes the old stream first so a bit arriving with start is
      // treated as the first bit of the new stream.
      rem_b = bus.start ? '0 : rem_q;
      w_b   = bus.start ? W_ONE : w_q;
      nz_b  = bus.start ? 1'b0 : nz_q;
      cnt_b = bus.start ? '0 : cnt_q;

      rem_n = rem_b;
      w_n   = w_b;
      nz_n  = nz_b;
      cnt_n = cnt_b;
      t     = '0;
      tw    = '0;

      if (bus.din_valid) begin
         if (LSB_FIRST != 0) begin
            // Add the current bit's weight; both operands are < DIVISOR so
            // the sum is < 2*DIVISOR and one subtract reduces it.
            t   = {1'b0, rem_b} + (bus.din ? {1'b0, w_b} : '0);
            tw  = {w_b, 1'b0};
            w_n = (tw >= DIV_C) ? RW'(tw - DIV_C) : tw[RW-1:0];
         end else begin
            // 2*rem + din, formed by appending the bit.
            t = {rem_b, bus.din};
         end
         rem_n = (t >= DIV_C) ? RW'(t - DIV_C) : t[RW-1:0];
         nz_n  = nz_b | bus.din;
         cnt_n = (&cnt_b) ? cnt_b : cnt_b + COUNT_W'(1);
      end
   end

   assign bus.rem       = rem_q;
   assign bus.nonzero   = nz_q;
   assign bus.divisible = (rem_q == '0) & nz_q;
   assign bus.bit_count = cnt_q;
endmodule

// File: tb/tb_serial_mod_detector.sv
// Purpose : scoreboard bench for serial_mod_detector across five divisor/bit-order/counter-width configurations.
// Ports   : none; drives clk/reset and one interface per instance.
// Latency : expected status is queued when a bit is driven and checked 1 ns after the capturing edge.
module tb_serial_mod_detector;
   localparam int N = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // instance table: 0 D5 MSB, 1 D5 LSB, 2 D3 LSB, 3 D5 MSB cw3, 4 D7 MSB
   int divs [N] = '{5, 5, 3, 5, 7};
   int lsbs [N] = '{0, 1, 1, 0, 0};
   int cws  [N] = '{8, 8, 8, 3, 8};

   logic st [N];
   logic dv [N];
   logic di [N];
   int   rem_o [N];
   int   div_o [N];
   int   nz_o  [N];
   int   cnt_o [N];

   serial_mod_detector_if #(.RW(3), .COUNT_W(8)) if0 ();
   serial_mod_detector_if #(.RW(3), .COUNT_W(8)) if1 ();
   serial_mod_detector_if #(.RW(2), .COUNT_W(8)) if2 ();
   serial_mod_detector_if #(.RW(3), .COUNT_W(3)) if3 ();
   serial_mod_detector_if #(.RW(3), .COUNT_W(8)) if4 ();

   serial_mod_detector #(.DIVISOR(5), .LSB_FIRST(0), .COUNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(if0));
   serial_mod_detector #(.DIVISOR(5), .LSB_FIRST(1), .COUNT_W(8)) u1 (.clk(clk), .reset(reset), .bus(if1));
   serial_mod_detector #(.DIVISOR(3), .LSB_FIRST(1), .COUNT_W(8)) u2 (.clk(clk), .reset(reset), .bus(if2));
   serial_mod_detector #(.DIVISOR(5), .LSB_FIRST(0), .COUNT_W(3)) u3 (.clk(clk), .reset(reset), .bus(if3));
   serial_mod_detector #(.DIVISOR(7), .LSB_FIRST(0), .COUNT_W(8)) u4 (.clk(clk), .reset(reset), .bus(if4));

   assign if0.start = st[0]; assign if0.din_valid = dv[0]; assign if0.din = di[0];
   assign if1.start = st[1]; assign if1.din_valid = dv[1]; assign if1.din = di[1];
   assign if2.start = st[2]; assign if2.din_valid = dv[2]; assign if2.din = di[2];
   assign if3.start = st[3]; assign if3.din_valid = dv[3]; assign if3.din = di[3];
   assign if4.start = st[4]; assign if4.din_valid = dv[4]; assign if4.din = di[4];

   assign rem_o[0] = int'(if0.rem); assign div_o[0] = int'(if0.divisible); assign nz_o[0] = int'(if0.nonzero); assign cnt_o[0] = int'(if0.bit_count);
   assign rem_o[1] = int'(if1.rem); assign div_o[1] = int'(if1.divisible); assign nz_o[1] = int'(if1.nonzero); assign cnt_o[1] = int'(if1.bit_count);
   assign rem_o[2] = int'(if2.rem); assign div_o[2] = int'(if2.divisible); assign nz_o[2] = int'(if2.nonzero); assign cnt_o[2] = int'(if2.bit_count);
   assign rem_o[3] = int'(if3.rem); assign div_o[3] = int'(if3.divisible); assign nz_o[3] = int'(if3.nonzero); assign cnt_o[3] = int'(if3.bit_count);
   assign rem_o[4] = int'(if4.rem); assign div_o[4] = int'(if4.divisible); assign nz_o[4] = int'(if4.nonzero); assign cnt_o[4] = int'(if4.bit_count);

   // reference model state, one slot per instance
   int m_rem [N];
   int m_w   [N];
   int m_nz  [N];
   int m_cnt [N];

   typedef struct {
      int    idx;
      int    rem;
      int    dvs;
      int    nz;
      int    cnt;
      string tag;
   } sb_t;
   sb_t sbq [$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int obs, input int want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, want);
      end
   endtask

   task automatic model_clear(input int k);
      m_rem[k] = 0;
      m_w[k]   = 1;
      m_nz[k]  = 0;
      m_cnt[k] = 0;
   endtask

   task automatic check_all(input int k, input string tag);
      chk({tag, "_rem"}, rem_o[k], m_rem[k]);
      chk({tag, "_div"}, div_o[k], (m_rem[k] == 0 && m_nz[k] != 0) ? 1 : 0);
      chk({tag, "_nz"},  nz_o[k],  m_nz[k]);
      chk({tag, "_cnt"}, cnt_o[k], m_cnt[k]);
   endtask

   // Drive one cycle on instance k, predict, then compare after the edge.
   task automatic step(input int k, input bit s, input bit v, input bit d, input string tag);
      sb_t e;
      sb_t g;
      st[k] = s; dv[k] = v; di[k] = d;
      if (s) model_clear(k);
      if (v) begin
         if (lsbs[k] != 0) begin
            m_rem[k] = (m_rem[k] + (d ? m_w[k] : 0)) % divs[k];
            m_w[k]   = (m_w[k] * 2) % divs[k];
         end else begin
            m_rem[k] = (m_rem[k] * 2 + int'(d)) % divs[k];
         end
         if (d) m_nz[k] = 1;
         if (m_cnt[k] < (1 << cws[k]) - 1) m_cnt[k]++;
      end
      e.idx = k; e.rem = m_rem[k]; e.nz = m_nz[k]; e.cnt = m_cnt[k];
      e.dvs = (m_rem[k] == 0 && m_nz[k] != 0) ? 1 : 0;
      e.tag = tag;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      st[k] = 1'b0; dv[k] = 1'b0; di[k] = 1'b0;
      g = sbq.pop_front();
      chk({g.tag, "_rem"}, rem_o[g.idx], g.rem);
      chk({g.tag, "_div"}, div_o[g.idx], g.dvs);
      chk({g.tag, "_nz"},  nz_o[g.idx],  g.nz);
      chk({g.tag, "_cnt"}, cnt_o[g.idx], g.cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         st[k] = 1'b0; dv[k] = 1'b0; di[k] = 1'b0;
         model_clear(k);
      end

      // reset state while reset is held
      #2;
      for (int k = 0; k < N; k++) check_all(k, "rst");
      @(posedge clk);
      #1 reset = 1'b0;

      // D5 MSB: 1,0,1 -> 5, 0 -> 10, 1 -> 21
      step(0, 1'b1, 1'b0, 1'b0, "msb_clr");
      step(0, 1'b0, 1'b1, 1'b1, "msb_b1");
      step(0, 1'b0, 1'b1, 1'b0, "msb_b2");
      step(0, 1'b0, 1'b1, 1'b1, "msb_b3");
      chk("msb_v5_div", div_o[0], 1);
      step(0, 1'b0, 1'b1, 1'b0, "msb_v10");
      step(0, 1'b0, 1'b1, 1'b1, "msb_v21");
      chk("msb_v21_rem", rem_o[0], 1);

      // only zeros: never divisible
      step(0, 1'b1, 1'b0, 1'b0, "zero_clr");
      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b0, "zero");
      chk("zero_cnt", cnt_o[0], 3);
      chk("zero_div", div_o[0], 0);

      // LSB-first D5: 1,0,1 = 5 ; D3: 1,1 = 3
      step(1, 1'b1, 1'b0, 1'b0, "lsb5_clr");
      step(1, 1'b0, 1'b1, 1'b1, "lsb5_b1");
      step(1, 1'b0, 1'b1, 1'b0, "lsb5_b2");
      step(1, 1'b0, 1'b1, 1'b1, "lsb5_b3");
      chk("lsb5_div", div_o[1], 1);
      step(1, 1'b0, 1'b1, 1'b0, "lsb5_tail0");
      step(2, 1'b1, 1'b0, 1'b0, "lsb3_clr");
      step(2, 1'b0, 1'b1, 1'b1, "lsb3_b1");
      step(2, 1'b0, 1'b1, 1'b1, "lsb3_b2");
      chk("lsb3_div", div_o[2], 1);

      // valid gaps hold state
      step(0, 1'b1, 1'b1, 1'b1, "gap_b1");
      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b1, "gap_idle");
      step(0, 1'b0, 1'b1, 1'b0, "gap_b2");
      chk("gap_cnt", cnt_o[0], 2);

      // start with a valid bit mid-stream, then start alone
      step(0, 1'b1, 1'b1, 1'b1, "sv_a");
      step(0, 1'b0, 1'b1, 1'b1, "sv_b");
      chk("sv_rem3", rem_o[0], 3);
      step(0, 1'b1, 1'b1, 1'b1, "sv_restart");
      chk("sv_restart_cnt", cnt_o[0], 1);
      step(0, 1'b1, 1'b0, 1'b0, "start_only");

      // async reset pulse between edges, mid-stream
      step(0, 1'b0, 1'b1, 1'b1, "ar_b1");
      step(0, 1'b0, 1'b1, 1'b1, "ar_b2");
      #3 reset = 1'b1;
      #1;
      for (int k = 0; k < N; k++) model_clear(k);
      check_all(0, "ar_async");
      #1 reset = 1'b0;
      step(0, 1'b0, 1'b1, 1'b1, "ar_first");

      // counter saturation, COUNT_W=3
      step(3, 1'b1, 1'b0, 1'b0, "sat_clr");
      for (int i = 0; i < 9; i++) step(3, 1'b0, 1'b1, 1'b1, "sat");
      chk("sat_cnt", cnt_o[3], 7);

      // random streams
      step(4, 1'b1, 1'b0, 1'b0, "r7_clr");
      for (int i = 0; i < 200; i++) step(4, 1'b0, 1'b1, 1'($urandom_range(0, 1)), "r7");
      step(1, 1'b1, 1'b0, 1'b0, "r5l_clr");
      for (int i = 0; i < 40; i++) step(1, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "r5l");
      step(2, 1'b1, 1'b0, 1'b0, "r3l_clr");
      for (int i = 0; i < 40; i++) step(2, 1'($urandom_range(0, 15) == 0), 1'b1, 1'($urandom_range(0, 1)), "r3l");

      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
